// File: rtl/dmem_request_arbiter.sv
// Arbiter between the LSU load path and the committed-store buffer head for the D-cache port.
// Define DMEM_ARB_PERF_EN to add grant/forced-store performance counters.
module dmem_request_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_mispredict,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_ready,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        sb_valid,
  input  logic [31:0] sb_addr,
  input  logic [3:0]  sb_wmask,
  input  logic [31:0] sb_wdata,
  input  logic        sb_full,
  input  logic        sb_ld_conflict,
  output logic        sb_pop,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_ld_grants,
  output logic [31:0] perf_st_grants,
  output logic [31:0] perf_forced
`endif
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StLoadWait, StStoreWait} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q;
  logic              squash_q;
  logic              ld_resp_q;
  logic [31:0]       ld_rdata_q;
  logic [31:0]       addr_q;
  logic [3:0]        rmask_q;
  logic [3:0]        wmask_q;
  logic [31:0]       wdata_q;
  logic              store_force;
  logic              grant_ld;
  logic              grant_st;

  // Byte offsets are dropped: the cache is addressed by word, masks select the bytes.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ld_addr[1:0], sb_addr[1:0]};

  always_comb begin
    store_force = sb_valid & (sb_full | sb_ld_conflict | (starve_cnt_q == StarveMax) | ~ld_valid);
    grant_st    = (state_q == StIdle) & store_force;
    grant_ld    = (state_q == StIdle) & ~store_force & ld_valid & ~branch_mispredict;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_st) begin
          state_d = StStoreWait;
        end else if (grant_ld) begin
          state_d = StLoadWait;
        end
      end
      StLoadWait, StStoreWait: begin
        if (dmem_resp) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ld_ready is gated by rst so that every output reads 0 while reset is held.
  always_comb begin
    ld_ready   = grant_ld & ~rst;
    sb_pop     = (state_q == StStoreWait) & dmem_resp;
    dmem_rmask = (state_q == StLoadWait) ? rmask_q : 4'h0;
    dmem_wmask = (state_q == StStoreWait) ? wmask_q : 4'h0;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    ld_resp    = ld_resp_q;
    ld_rdata   = ld_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      squash_q     <= 1'b0;
      ld_resp_q    <= 1'b0;
      ld_rdata_q   <= 32'h0;
      addr_q       <= 32'h0;
      rmask_q      <= 4'h0;
      wmask_q      <= 4'h0;
      wdata_q      <= 32'h0;
    end else begin
      ld_resp_q <= 1'b0;
      if (grant_ld) begin
        addr_q  <= {ld_addr[31:2], 2'b00};
        rmask_q <= ld_rmask;
        if (!sb_valid) begin
          starve_cnt_q <= '0;
        end else if (starve_cnt_q != StarveMax) begin
          starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
      end else if (grant_st) begin
        addr_q       <= {sb_addr[31:2], 2'b00};
        wmask_q      <= sb_wmask;
        wdata_q      <= sb_wdata;
        starve_cnt_q <= '0;
      end
      // A mispredict coinciding with the response also suppresses it.
      if (state_q == StLoadWait) begin
        if (dmem_resp) begin
          ld_resp_q  <= ~(squash_q | branch_mispredict);
          ld_rdata_q <= dmem_rdata;
          squash_q   <= 1'b0;
        end else if (branch_mispredict) begin
          squash_q <= 1'b1;
        end
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ld_grants <= 32'h0;
      perf_st_grants <= 32'h0;
      perf_forced    <= 32'h0;
    end else begin
      if (grant_ld) begin
        perf_ld_grants <= perf_ld_grants + 32'd1;
      end
      if (grant_st) begin
        perf_st_grants <= perf_st_grants + 32'd1;
      end
      // With ld_valid high a store grant can only come from full, conflict or starvation.
      if (grant_st && ld_valid) begin
        perf_forced <= perf_forced + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_request_arbiter.sv
// Self-checking bench for dmem_request_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_dmem_request_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_mispredict;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_ready;
  logic        ld_resp;
  logic [31:0] ld_rdata;
  logic        sb_valid;
  logic [31:0] sb_addr;
  logic [3:0]  sb_wmask;
  logic [31:0] sb_wdata;
  logic        sb_full;
  logic        sb_ld_conflict;
  logic        sb_pop;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_ld_grants;
  logic [31:0] perf_st_grants;
  logic [31:0] perf_forced;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_request_arbiter #(
    .STARVE_LIMIT(8),
    .CNT_W       (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_mispredict(branch_mispredict),
    .ld_valid         (ld_valid),
    .ld_addr          (ld_addr),
    .ld_rmask         (ld_rmask),
    .ld_ready         (ld_ready),
    .ld_resp          (ld_resp),
    .ld_rdata         (ld_rdata),
    .sb_valid         (sb_valid),
    .sb_addr          (sb_addr),
    .sb_wmask         (sb_wmask),
    .sb_wdata         (sb_wdata),
    .sb_full          (sb_full),
    .sb_ld_conflict   (sb_ld_conflict),
    .sb_pop           (sb_pop),
    .dmem_addr        (dmem_addr),
    .dmem_rmask       (dmem_rmask),
    .dmem_wmask       (dmem_wmask),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_ld_grants   (perf_ld_grants),
    .perf_st_grants   (perf_st_grants),
    .perf_forced      (perf_forced)
`endif
  );

  task automatic idle_inputs();
    branch_mispredict = 1'b0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_rmask = 4'h0;
    sb_valid = 1'b0; sb_addr = 32'h0; sb_wmask = 4'h0; sb_wdata = 32'h0;
    sb_full = 1'b0; sb_ld_conflict = 1'b0;
    dmem_rdata = 32'h0; dmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b1; ld_rmask = 4'h1; dmem_resp = 1'b1;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    checks++; if (ld_resp !== 1'b0) begin errors++; $display("FAIL reset_ld_resp: got %b want 0", ld_resp); end
    checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL reset_ld_rdata: got %h want 0", ld_rdata); end
    checks++; if (sb_pop !== 1'b0) begin errors++; $display("FAIL reset_sb_pop: got %b want 0", sb_pop); end
    checks++; if (dmem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", dmem_addr); end
    checks++; if (dmem_rmask !== 4'h0) begin errors++; $display("FAIL reset_rmask: got %h want 0", dmem_rmask); end
    checks++; if (dmem_wmask !== 4'h0) begin errors++; $display("FAIL reset_wmask: got %h want 0", dmem_wmask); end
    checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", dmem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load();
    do_reset();
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h1000_0006; ld_rmask = 4'h4;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", ld_ready); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ld_valid = 1'b0;
      dmem_resp = (c == 3);
      dmem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      checks++; if (dmem_addr !== 32'h1000_0004) begin errors++; $display("FAIL load_addr: got %h want 10000004", dmem_addr); end
      checks++; if (dmem_rmask !== 4'h4 || dmem_wmask !== 4'h0) begin
        errors++; $display("FAIL load_masks: got r=%h w=%h want r=4 w=0", dmem_rmask, dmem_wmask);
      end
      checks++; if (ld_resp !== 1'b0) begin errors++; $display("FAIL load_early_resp: got %b want 0", ld_resp); end
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    checks++; if (ld_resp !== 1'b1) begin errors++; $display("FAIL load_resp: got %b want 1", ld_resp); end
    checks++; if (ld_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", ld_rdata); end
    checks++; if (dmem_rmask !== 4'h0) begin errors++; $display("FAIL load_idle_rmask: got %h want 0", dmem_rmask); end
    @(negedge clk);
    #1;
    checks++; if (ld_resp !== 1'b0) begin errors++; $display("FAIL load_resp_pulse: got %b want 0", ld_resp); end
  endtask

  task automatic test_store();
    do_reset();
    @(negedge clk);
    sb_valid = 1'b1; sb_addr = 32'h2000_0008; sb_wmask = 4'hF; sb_wdata = 32'h1234_5678;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL store_ld_ready: got %b want 0", ld_ready); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      dmem_resp = (c == 3);
      #1;
      checks++; if (dmem_wmask !== 4'hF || dmem_rmask !== 4'h0) begin
        errors++; $display("FAIL store_masks: got w=%h r=%h want w=f r=0", dmem_wmask, dmem_rmask);
      end
      checks++; if (dmem_addr !== 32'h2000_0008 || dmem_wdata !== 32'h1234_5678) begin
        errors++; $display("FAIL store_data: got a=%h d=%h want 20000008/12345678", dmem_addr, dmem_wdata);
      end
      checks++; if (sb_pop !== (c == 3)) begin errors++; $display("FAIL store_pop: got %b want %b", sb_pop, (c == 3)); end
    end
    @(negedge clk);
    sb_valid = 1'b0; dmem_resp = 1'b0;
    #1;
    checks++; if (sb_pop !== 1'b0 || ld_resp !== 1'b0) begin
      errors++; $display("FAIL store_after: got pop=%b ld_resp=%b want 0/0", sb_pop, ld_resp);
    end
    checks++; if (dmem_wmask !== 4'h0) begin errors++; $display("FAIL store_idle_wmask: got %h want 0", dmem_wmask); end
  endtask

  // Two cycles per transaction with an always-responding cache: 8 loads then one store, repeating.
  task automatic test_starvation();
    int t;
    int k;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 32'h4000_0000 + 32'(c * 4); ld_rmask = 4'h1;
      sb_valid = 1'b1; sb_addr = 32'h5000_0000; sb_wmask = 4'hF; sb_wdata = 32'(c);
      dmem_resp = 1'b1; dmem_rdata = 32'hA000_0000 + 32'(c);
      #1;
      t = c / 2;
      k = t % 9;
      if (c % 2 == 0) begin
        checks++; if (ld_ready !== (k < 8)) begin
          errors++; $display("FAIL starve_grant c=%0d: got %b want %b", c, ld_ready, (k < 8));
        end
        checks++; if (ld_resp !== (t > 0 && ((t - 1) % 9) < 8)) begin
          errors++; $display("FAIL starve_ld_resp c=%0d: got %b", c, ld_resp);
        end
        if (t > 0 && ((t - 1) % 9) < 8) begin
          checks++; if (ld_rdata !== 32'hA000_0000 + 32'(c - 1)) begin
            errors++; $display("FAIL starve_rdata c=%0d: got %h want %h", c, ld_rdata, 32'hA000_0000 + 32'(c - 1));
          end
        end
      end else begin
        checks++; if (sb_pop !== (k == 8)) begin
          errors++; $display("FAIL starve_pop c=%0d: got %b want %b", c, sb_pop, (k == 8));
        end
      end
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h0000_0100; ld_rmask = 4'h3;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL misp_grant: got %b want 1", ld_ready); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      ld_valid = 1'b0;
      branch_mispredict = (c == 1);
      dmem_resp = (c == 3); dmem_rdata = 32'h1111_2222;
      #1;
      checks++; if (dmem_rmask !== 4'h3) begin errors++; $display("FAIL misp_rmask c=%0d: got %h want 3", c, dmem_rmask); end
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h0000_0200; ld_rmask = 4'hC; branch_mispredict = 1'b1;
    #1;
    checks++; if (ld_resp !== 1'b0) begin errors++; $display("FAIL misp_squash: got %b want 0", ld_resp); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL misp_idle_block: got %b want 0", ld_ready); end
    @(negedge clk);
    branch_mispredict = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL misp_regrant: got %b want 1", ld_ready); end
    @(negedge clk);
    ld_valid = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL misp_next_resp: got %b/%h want 1/cafef00d", ld_resp, ld_rdata);
    end
  endtask

  task automatic test_conflict();
    int sb_cnt = 2;
    int pops = 0;
    int first_ld = -1;
    do_reset();
    for (int c = 0; c < 12 && first_ld < 0; c++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 32'h3000_0010; ld_rmask = 4'hF;
      sb_valid = (sb_cnt > 0); sb_ld_conflict = (sb_cnt > 0);
      sb_addr = 32'h3000_0010; sb_wmask = 4'h1; sb_wdata = 32'(sb_cnt);
      dmem_resp = 1'b1;
      #1;
      if (sb_pop === 1'b1) begin
        pops++;
        sb_cnt--;
      end
      if (ld_ready === 1'b1) first_ld = c;
    end
    checks++; if (pops != 2) begin errors++; $display("FAIL conflict_pops: got %0d want 2", pops); end
    checks++; if (first_ld != 4) begin errors++; $display("FAIL conflict_ld_cycle: got %0d want 4", first_ld); end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    @(negedge clk);
    sb_valid = 1'b1; sb_addr = 32'h6000_0004; sb_wmask = 4'h3; sb_wdata = 32'h5555_AAAA;
    @(negedge clk);
    #1;
    checks++; if (dmem_wmask !== 4'h3) begin errors++; $display("FAIL rms_in_store: got %h want 3", dmem_wmask); end
    #1;
    rst = 1'b1; dmem_resp = 1'b1;
    #1;
    checks++; if (sb_pop !== 1'b0) begin errors++; $display("FAIL rms_pop: got %b want 0", sb_pop); end
    checks++; if (dmem_wmask !== 4'h0 || dmem_rmask !== 4'h0) begin
      errors++; $display("FAIL rms_masks: got w=%h r=%h want 0/0", dmem_wmask, dmem_rmask);
    end
    checks++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
      errors++; $display("FAIL rms_addr_data: got %h/%h want 0/0", dmem_addr, dmem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (sb_pop !== 1'b0 || dmem_wmask !== 4'h0) begin
      errors++; $display("FAIL rms_after: got pop=%b w=%h want 0/0", sb_pop, dmem_wmask);
    end
    @(negedge clk);
    ld_valid = 1'b1; ld_rmask = 4'h1;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rms_idle_grant: got %b want 1", ld_ready); end
  endtask

  // Reference model: one outstanding transaction record (none/load/store) plus the spec's
  // starvation, squash and response-latency rules.
  task automatic test_random();
    int          kind = 0;
    int          streak = 0;
    int          lat = 0;
    bit          squash = 1'b0;
    bit          resp_now = 1'b0;
    bit          resp_next;
    bit          force_st, e_ready, e_pop;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;
    logic [3:0]  m_rmask = 4'h0, m_wmask = 4'h0;
    logic [3:0]  e_rmask, e_wmask;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      ld_valid = ($urandom % 4) != 0;
      ld_addr = $urandom;
      ld_rmask = 4'($urandom_range(1, 15));
      sb_valid = ($urandom % 2) != 0;
      sb_addr = $urandom; sb_wmask = 4'($urandom); sb_wdata = $urandom;
      sb_full = ($urandom % 8) == 0;
      sb_ld_conflict = ($urandom % 6) == 0;
      branch_mispredict = ($urandom % 8) == 0;
      dmem_rdata = $urandom;
      if (kind != 0) begin
        dmem_resp = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        dmem_resp = ($urandom % 4) == 0;
      end
      #1;
      force_st = sb_valid && (sb_full || sb_ld_conflict || streak == 8 || !ld_valid);
      e_ready = (kind == 0) && !force_st && ld_valid && !branch_mispredict;
      e_pop = (kind == 2) && dmem_resp;
      e_rmask = (kind == 1) ? m_rmask : 4'h0;
      e_wmask = (kind == 2) ? m_wmask : 4'h0;
      checks++; if (ld_ready !== e_ready) begin errors++; $display("FAIL rnd_ld_ready c=%0d: got %b want %b", c, ld_ready, e_ready); end
      checks++; if (sb_pop !== e_pop) begin errors++; $display("FAIL rnd_sb_pop c=%0d: got %b want %b", c, sb_pop, e_pop); end
      checks++; if (dmem_rmask !== e_rmask) begin errors++; $display("FAIL rnd_rmask c=%0d: got %h want %h", c, dmem_rmask, e_rmask); end
      checks++; if (dmem_wmask !== e_wmask) begin errors++; $display("FAIL rnd_wmask c=%0d: got %h want %h", c, dmem_wmask, e_wmask); end
      checks++; if (dmem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, dmem_addr, m_addr); end
      checks++; if (dmem_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, dmem_wdata, m_wdata); end
      checks++; if (ld_resp !== resp_now) begin errors++; $display("FAIL rnd_ld_resp c=%0d: got %b want %b", c, ld_resp, resp_now); end
      checks++; if (ld_rdata !== m_rdata) begin errors++; $display("FAIL rnd_ld_rdata c=%0d: got %h want %h", c, ld_rdata, m_rdata); end
      resp_next = 1'b0;
      if (kind == 0) begin
        if (force_st) begin
          kind = 2; m_addr = {sb_addr[31:2], 2'b00}; m_wmask = sb_wmask; m_wdata = sb_wdata;
          streak = 0; lat = $urandom_range(0, 3);
        end else if (e_ready) begin
          kind = 1; m_addr = {ld_addr[31:2], 2'b00}; m_rmask = ld_rmask;
          streak = sb_valid ? ((streak < 8) ? streak + 1 : 8) : 0;
          lat = $urandom_range(0, 3);
        end
      end else if (kind == 1) begin
        if (dmem_resp) begin
          resp_next = !(squash || branch_mispredict);
          m_rdata = dmem_rdata; squash = 1'b0; kind = 0;
        end else if (branch_mispredict) begin
          squash = 1'b1;
        end
      end else if (dmem_resp) begin
        kind = 0;
      end
      resp_now = resp_next;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_store();
    test_starvation();
    test_mispredict();
    test_conflict();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_request_arbiter.md
Name: dmem_request_arbiter

Overview:
- Sequential arbiter between the load path of the load/store unit and the head of the committed-store buffer; sole owner of the data-cache upstream port.
- Registers the granted request and holds it stable on dmem_* until dmem_resp.
- Prioritises loads, with store-drain forcing on buffer-full, load/store conflict or starvation.
- Squashes load responses across a branch mispredict.

Parameters:
- STARVE_LIMIT, 8: consecutive load grants with sb_valid high before a store grant is forced.
- CNT_W, 4: width of the starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- branch_mispredict  input  1  flush pulse from ROB
- ld_valid  input  1  load request pending
- ld_addr  input  32  load byte address
- ld_rmask  input  4  load byte mask, nonzero when ld_valid
- ld_ready  output  1  load accepted this cycle
- ld_resp  output  1  registered load-completion pulse
- ld_rdata  output  32  raw aligned word for the load
- sb_valid  input  1  store-buffer head valid
- sb_addr  input  32  head store byte address
- sb_wmask  input  4  head store byte mask
- sb_wdata  input  32  head store data
- sb_full  input  1  store buffer full
- sb_ld_conflict  input  1  some buffered store overlaps ld_addr/ld_rmask
- sb_pop  output  1  head store written; pulse
- dmem_addr  output  32  word-aligned address to D-cache
- dmem_rmask  output  4  read mask
- dmem_wmask  output  4  write mask
- dmem_wdata  output  32  write data
- dmem_rdata  input  32  cache read data
- dmem_resp  input  1  cache response

Behaviour:
- States: IDLE, LOAD_WAIT, STORE_WAIT.
- Reset (async):
  - state=IDLE, starve_cnt=0, squash=0.
  - All outputs 0: ld_ready, ld_resp, ld_rdata, sb_pop, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata.
  - Reset mid-transaction abandons it silently.
- IDLE grant rule, evaluated combinationally:
  - store_force = sb_valid & (sb_full | sb_ld_conflict | starve_cnt==STARVE_LIMIT | !ld_valid).
  - If store_force: grant store.
  - Else if ld_valid & !branch_mispredict: grant load.
  - Else stay in IDLE.
- Load grant:
  - ld_ready=1 for that cycle.
  - Register {ld_addr[31:2],2'b00} and ld_rmask; go to LOAD_WAIT.
  - starve_cnt increments if sb_valid, else clears.
- Store grant:
  - Register aligned sb_addr, sb_wmask, sb_wdata; go to STORE_WAIT.
  - starve_cnt clears.
- Held request:
  - In LOAD_WAIT/STORE_WAIT, dmem_* are driven from registers and held constant until dmem_resp.
  - Exactly one of rmask/wmask is nonzero; both masks are 0 in IDLE; dmem_addr/wdata keep last value.
- LOAD_WAIT with dmem_resp:
  - Next cycle: ld_resp=!squash, ld_rdata=dmem_rdata (registered, one-cycle latency).
  - squash clears; state goes to IDLE.
- STORE_WAIT with dmem_resp: sb_pop pulses in the same cycle (combinational); state goes to IDLE.
- Turnaround: minimum one IDLE cycle between transactions; throughput is one access per (cache latency + 1) cycles.
- branch_mispredict:
  - In LOAD_WAIT: set squash; the request still completes to the cache, but ld_resp is suppressed.
  - Coinciding with dmem_resp in LOAD_WAIT: response suppressed.
  - In IDLE: blocks the load grant that cycle.
  - Stores are committed and never squashed; STORE_WAIT is unaffected.
- sb_ld_conflict with a valid load: the load is stalled until the conflict clears; stores drain one per transaction.
- dmem_resp in IDLE is ignored.
- starve_cnt saturates at STARVE_LIMIT.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, adds three 32-bit outputs, each cleared by reset and wrapping at 2^32:
  - perf_ld_grants: load grants.
  - perf_st_grants: store grants.
  - perf_forced: store grants caused by sb_full, conflict or starvation while ld_valid was high.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- ld_valid=1, ld_addr=0x1000_0006, rmask=0x4, no store; cache resp after 3 cycles with 0xDEADBEEF -> ld_ready in cycle 0, dmem_addr=0x1000_0004, rmask held 3 cycles, ld_resp=1 with ld_rdata=0xDEADBEEF one cycle after dmem_resp.
- sb_valid=1, sb_addr=0x2000_0008, wmask=0xF, wdata=0x1234_5678, ld_valid=0 -> STORE_WAIT, dmem_wmask=0xF held until resp, sb_pop same cycle as dmem_resp, no ld_resp.
- ld_valid and sb_valid held high continuously, 1-cycle cache -> exactly 8 load grants, then one forced store grant, then the pattern repeats; starve_cnt returns to 0.
- Load issued, branch_mispredict pulses mid LOAD_WAIT -> cache sees full read, ld_resp stays 0; next load gets a normal ld_resp.
- ld_valid with sb_ld_conflict=1 and two buffered stores -> two stores drain (two sb_pop), then the load is granted once conflict drops.
- Assert rst during STORE_WAIT -> all outputs 0 immediately, no sb_pop; state IDLE after release.
